// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package : riscv_pkg
// Shared types and helpers for the five-stage core hazard/sequencing logic.
// Revision: 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int REG_IDX_W = 5;

  // ALU operand source select for the E stage
  typedef enum logic [1:0] {
    REGF  = 2'b00,
    FWD_W = 2'b01,
    FWD_M = 2'b10
  } fwd_sel_t;

  // Memory-freeze sequencing states
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_ERR  = 2'b10
  } hz_state_t;

  // True when a writing instruction targets a non-zero register read by a source
  function automatic logic reg_hit(input logic                 we,
                                   input logic [REG_IDX_W-1:0] rd,
                                   input logic [REG_IDX_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : hazard_ctrl_if
// Pipeline-side signal bundle of the hazard controller. The slave modport is
// the controller, the master modport is the datapath that consumes controls.
// Revision: 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import riscv_pkg::*;

  // Register indices and hazard sources
  logic [REG_IDX_W-1:0] rs1D;
  logic [REG_IDX_W-1:0] rs2D;
  logic [REG_IDX_W-1:0] rs1E;
  logic [REG_IDX_W-1:0] rs2E;
  logic [REG_IDX_W-1:0] rdE;
  logic                 loadE;
  logic                 pcSrcE;
  logic [REG_IDX_W-1:0] rdM;
  logic                 regWriteM;
  logic [REG_IDX_W-1:0] rdW;
  logic                 regWriteW;
  logic                 memReqM;
  logic                 memReadyM;
  logic                 errClr;

  // Stage-register controls
  logic                 stallF;
  logic                 stallD;
  logic                 stallE;
  logic                 stallM;
  logic                 flushD;
  logic                 flushE;
  logic                 flushW;
  logic [1:0]           forwardAE;
  logic [1:0]           forwardBE;
  logic                 memErr;
  logic [CNT_W-1:0]     stallCnt;
  logic [CNT_W-1:0]     flushCnt;

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, loadE, pcSrcE,
           rdM, regWriteM, rdW, regWriteW, memReqM, memReadyM, errClr,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAE, forwardBE, memErr, stallCnt, flushCnt
  );

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, loadE, pcSrcE,
           rdM, regWriteM, rdW, regWriteW, memReqM, memReadyM, errClr,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAE, forwardBE, memErr, stallCnt, flushCnt
  );

endinterface
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module  : fwd_sel
// Forwarding comparator for one E-stage ALU operand. The M-stage result is
// younger than the W-stage result, so it wins when both match.
// Revision: 1.0 - initial release
// ============================================================================
module fwd_sel
  import riscv_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_rsE,
  input  logic [REG_IDX_W-1:0] i_rdM,
  input  logic                 i_regWriteM,
  input  logic [REG_IDX_W-1:0] i_rdW,
  input  logic                 i_regWriteW,
  output fwd_sel_t             o_sel
);

  // Priority select: M over W over register file
  always_comb begin
    o_sel = REGF;
    if (reg_hit(i_regWriteM, i_rdM, i_rsE)) begin
      o_sel = FWD_M;
    end else if (reg_hit(i_regWriteW, i_rdW, i_rsE)) begin
      o_sel = FWD_W;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Stall/flush/forward controller for the five-stage core. Resolves load-use
// and taken-branch hazards, freezes the pipeline across multi-cycle data
// memory accesses with a watchdog, and counts stall and flush cycles.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  hazard_ctrl_if.slave hz
);

  // Wait counter only has to reach MEM_TIMEOUT-1
  localparam int               c_WC_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WC_W-1:0] c_WAIT_LAST = c_WC_W'(MEM_TIMEOUT - 1);

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic [c_WC_W-1:0] r_waitCnt;
  logic [c_WC_W-1:0] w_waitCnt_nxt;
  logic [CNT_W-1:0]  r_stallCnt;
  logic [CNT_W-1:0]  r_flushCnt;

  logic              w_freeze;
  logic              w_errClrCyc;
  logic              w_lwStall;
  logic              w_stallF;
  logic              w_stallD;
  logic              w_stallE;
  logic              w_stallM;
  logic              w_flushD;
  logic              w_flushE;
  logic              w_flushW;
  fwd_sel_t          w_fwdA;
  fwd_sel_t          w_fwdB;

  // One comparator per ALU operand
  fwd_sel u_fwd_a (
    .i_rsE       (hz.rs1E),
    .i_rdM       (hz.rdM),
    .i_regWriteM (hz.regWriteM),
    .i_rdW       (hz.rdW),
    .i_regWriteW (hz.regWriteW),
    .o_sel       (w_fwdA)
  );

  fwd_sel u_fwd_b (
    .i_rsE       (hz.rs2E),
    .i_rdM       (hz.rdM),
    .i_regWriteM (hz.regWriteM),
    .i_rdW       (hz.rdW),
    .i_regWriteW (hz.regWriteW),
    .o_sel       (w_fwdB)
  );

  // Hazard conditions; a same-cycle memReadyM in RUN never freezes
  always_comb begin
    w_lwStall   = hz.loadE && (hz.rdE != '0) &&
                  ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
    w_errClrCyc = (r_state == MEM_ERR) && hz.errClr;
    w_freeze    = ((r_state == RUN)      && hz.memReqM && !hz.memReadyM) ||
                  ((r_state == MEM_WAIT) && !hz.memReadyM) ||
                  (r_state == MEM_ERR);
  end

  // Next state and watchdog count
  always_comb begin
    w_state_nxt   = r_state;
    w_waitCnt_nxt = r_waitCnt;
    case (r_state)
      RUN: begin
        w_waitCnt_nxt = '0;
        if (hz.memReqM && !hz.memReadyM) begin
          w_state_nxt   = MEM_WAIT;
          w_waitCnt_nxt = c_WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.memReadyM) begin
          w_state_nxt   = RUN;
          w_waitCnt_nxt = '0;
        end else if (r_waitCnt == c_WAIT_LAST) begin
          w_state_nxt   = MEM_ERR;
          w_waitCnt_nxt = '0;
        end else begin
          w_waitCnt_nxt = r_waitCnt + 1'b1;
        end
      end
      MEM_ERR: begin
        w_waitCnt_nxt = '0;
        if (hz.errClr) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt   = RUN;
        w_waitCnt_nxt = '0;
      end
    endcase
  end

  // Stage controls; reset forces bubbles everywhere and releases stalls
  always_comb begin
    w_stallF = 1'b0;
    w_stallD = 1'b0;
    w_stallE = 1'b0;
    w_stallM = 1'b0;
    w_flushD = 1'b0;
    w_flushE = 1'b0;
    w_flushW = 1'b0;
    if (!reset_n || w_errClrCyc) begin
      w_flushD = 1'b1;
      w_flushE = 1'b1;
      w_flushW = 1'b1;
    end else if (w_freeze) begin
      w_stallF = 1'b1;
      w_stallD = 1'b1;
      w_stallE = 1'b1;
      w_stallM = 1'b1;
      w_flushW = 1'b1;
    end else begin
      w_stallF = w_lwStall;
      w_stallD = w_lwStall;
      w_flushD = hz.pcSrcE;
      w_flushE = w_lwStall || hz.pcSrcE;
    end
  end

  // State register and watchdog
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= RUN;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_waitCnt <= w_waitCnt_nxt;
    end
  end

  // Performance counters, wrapping naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stallF) r_stallCnt <= r_stallCnt + 1'b1;
      if (w_flushD) r_flushCnt <= r_flushCnt + 1'b1;
    end
  end

  // Drive the bundle
  always_comb begin
    hz.stallF    = w_stallF;
    hz.stallD    = w_stallD;
    hz.stallE    = w_stallE;
    hz.stallM    = w_stallM;
    hz.flushD    = w_flushD;
    hz.flushE    = w_flushE;
    hz.flushW    = w_flushW;
    hz.forwardAE = reset_n ? w_fwdA : REGF;
    hz.forwardBE = reset_n ? w_fwdB : REGF;
    hz.memErr    = (r_state == MEM_ERR);
    hz.stallCnt  = r_stallCnt;
    hz.flushCnt  = r_flushCnt;
  end

endmodule
`default_nettype wire
